// File: rtl/fpu_md_scheduler_pkg.sv
// fpu_md_scheduler_pkg: opcodes, latencies and FSM encoding shared by the mult/div scheduler
package fpu_md_scheduler_pkg;
  localparam logic [5:0] OP_FMUL = 6'h37;
  localparam logic [5:0] OP_FDIV = 6'h38;
  localparam int LAT_FMUL = 14;
  localparam int LAT_FDIV = 20;
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_e;
endpackage

// File: rtl/fpu_md_scheduler_rr_arbiter.sv
// fpu_md_scheduler_rr_arbiter: combinational round-robin pick starting at ptr_i
module fpu_md_scheduler_rr_arbiter #(
  parameter int NREQ = 4,
  localparam int IW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IW-1:0]   idx_o,
  output logic            valid_o
);
  int j;
  // Scan from farthest to nearest so the requester closest to ptr_i wins.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    valid_o = 1'b0;
    j = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = int'(ptr_i) + k;
      j = (j >= NREQ) ? j - NREQ : j;
      if (req_i[j]) begin
        gnt_o = '0;
        gnt_o[j] = 1'b1;
        idx_o = j[IW-1:0];
        valid_o = 1'b1;
      end
    end
  end
endmodule

// File: rtl/fpu_md_scheduler.sv
// fpu_md_scheduler: shares one mult/div unit between NREQ requesters with a valid/ready response port
module fpu_md_scheduler
  import fpu_md_scheduler_pkg::*;
#(
  parameter int          NREQ    = 4,
  parameter int          N       = 32,
  parameter int          L       = 4,
  parameter int          TAGW    = 4,
  parameter logic [5:0]  FMUL    = OP_FMUL,
  parameter logic [5:0]  FDIV    = OP_FDIV,
  parameter int          TIMEOUT = 64
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NREQ-1:0]             req_valid,
  output logic [NREQ-1:0]             req_ready,
  input  logic [6*NREQ-1:0]           req_opcode,
  input  logic [N*L*NREQ-1:0]         req_a,
  input  logic [N*L*NREQ-1:0]         req_b,
  input  logic [TAGW*NREQ-1:0]        req_tag,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [$clog2(NREQ)-1:0]     rsp_id,
  output logic [TAGW-1:0]             rsp_tag,
  output logic [N*L-1:0]              rsp_data,
  output logic                        rsp_err,
  output logic                        fpu_ivalid,
  output logic [5:0]                  fpu_opcode,
  output logic [N*L-1:0]              fpu_a,
  output logic [N*L-1:0]              fpu_b,
  output logic                        fpu_stall,
  input  logic [N*L-1:0]              fpu_o,
  input  logic                        fpu_finish,
  output logic                        busy
);
  localparam int IW = $clog2(NREQ);
  localparam int W  = N * L;
  localparam int CW = $clog2(TIMEOUT);

  state_e            state_q, state_d;
  logic [IW-1:0]     rr_ptr_q, id_q, gidx;
  logic [NREQ-1:0]   gnt;
  logic              gany, legal, timeout, take, in_busy;
  logic [5:0]        op_q, win_op;
  logic [W-1:0]      a_q, b_q, data_q;
  logic [TAGW-1:0]   tag_q;
  logic              err_q;
  logic [CW-1:0]     cnt_q;

  fpu_md_scheduler_rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req_i   (req_valid),
    .ptr_i   (rr_ptr_q),
    .gnt_o   (gnt),
    .idx_o   (gidx),
    .valid_o (gany)
  );

  assign win_op  = req_opcode[gidx*6 +: 6];
  assign legal   = (win_op == FMUL) || (win_op == FDIV);
  assign timeout = cnt_q == CW'(TIMEOUT - 1);
  assign take    = (state_q == IDLE) && gany;
  assign in_busy = state_q == BUSY;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Finish has priority over timeout; RESP always returns through IDLE so ivalid drops for a cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = !gany ? IDLE : legal ? BUSY : RESP;
      BUSY:    state_d = (fpu_finish || timeout) ? RESP : BUSY;
      RESP:    state_d = rsp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state_q == IDLE) ? gnt : '0;
    busy       = state_q != IDLE;
    rsp_valid  = state_q == RESP;
    rsp_id     = id_q;
    rsp_tag    = tag_q;
    rsp_data   = data_q;
    rsp_err    = err_q;
    fpu_ivalid = in_busy;
    fpu_stall  = in_busy;
    fpu_opcode = in_busy ? op_q : '0;
    fpu_a      = in_busy ? a_q : '0;
    fpu_b      = in_busy ? b_q : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
      id_q     <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      tag_q    <= '0;
      data_q   <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      if (take) begin
        op_q     <= win_op;
        a_q      <= req_a[gidx*W +: W];
        b_q      <= req_b[gidx*W +: W];
        tag_q    <= req_tag[gidx*TAGW +: TAGW];
        id_q     <= gidx;
        rr_ptr_q <= (gidx == IW'(NREQ - 1)) ? '0 : gidx + 1'b1;
        cnt_q    <= '0;
        data_q   <= '0;
        err_q    <= !legal;
      end
      if (in_busy) begin
        cnt_q <= cnt_q + 1'b1;
        if (fpu_finish) begin
          data_q <= fpu_o;
          err_q  <= 1'b0;
        end else if (timeout) begin
          data_q <= '0;
          err_q  <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_fpu_md_scheduler.sv
// tb_fpu_md_scheduler: vector table, corner sequences and randomized traffic against a transaction-level model
module tb_fpu_md_scheduler;
  import fpu_md_scheduler_pkg::*;
  localparam int NREQ = 4, N = 32, L = 4, TAGW = 4, W = N * L;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NREQ-1:0]      req_valid = '0, req_ready;
  logic [6*NREQ-1:0]    req_opcode = '0;
  logic [W*NREQ-1:0]    req_a = '0, req_b = '0;
  logic [TAGW*NREQ-1:0] req_tag = '0;
  logic                 rsp_valid, rsp_ready = 1'b1, rsp_err;
  logic [1:0]           rsp_id;
  logic [TAGW-1:0]      rsp_tag;
  logic [W-1:0]         rsp_data, fpu_a, fpu_b, fpu_o;
  logic                 fpu_ivalid, fpu_stall, fpu_finish, busy;
  logic [5:0]           fpu_opcode;

  fpu_md_scheduler dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_tag(rsp_tag), .rsp_data(rsp_data), .rsp_err(rsp_err), .fpu_ivalid(fpu_ivalid),
    .fpu_opcode(fpu_opcode), .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_stall(fpu_stall), .fpu_o(fpu_o),
    .fpu_finish(fpu_finish), .busy(busy)
  );

  int checks = 0, errors = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W-1:0] ref_res(input logic [5:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    logic [N-1:0] x, y;
    r = '0;
    for (int l = 0; l < L; l++) begin
      x = a[l*N +: N];
      y = b[l*N +: N];
      r[l*N +: N] = (op == OP_FMUL) ? x * y : (y == 0) ? '1 : x / y;
    end
    return r;
  endfunction

  // Shared-unit model: counts ivalid cycles and finishes at the opcode latency.
  logic [6:0] ucnt = '0;
  bit never_fin = 1'b0;
  always @(posedge clk) ucnt <= fpu_ivalid ? ucnt + 7'd1 : 7'd0;
  assign fpu_finish = fpu_ivalid && !never_fin &&
                      (int'(ucnt) == ((fpu_opcode == OP_FMUL) ? LAT_FMUL : LAT_FDIV));
  assign fpu_o = fpu_finish ? ref_res(fpu_opcode, fpu_a, fpu_b) : ~ref_res(fpu_opcode, fpu_a, fpu_b);

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic set_req(input int id, input logic [5:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [TAGW-1:0] tag);
    req_opcode[id*6 +: 6] = op;
    req_a[id*W +: W] = a;
    req_b[id*W +: W] = b;
    req_tag[id*TAGW +: TAGW] = tag;
    req_valid[id] = 1'b1;
  endtask

  task automatic wait_grant(output logic [NREQ-1:0] g, output int t);
    g = '0;
    t = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (req_ready != 0) begin
        g = req_ready;
        t = cyc;
        break;
      end
    end
    if (t < 0) begin
      checks++;
      errors++;
      $display("FAIL grant_wait: no req_ready within 200 cycles");
    end
  endtask

  task automatic wait_rsp(output int t, output int iv);
    t = -1;
    iv = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (rsp_valid) begin
        t = cyc;
        break;
      end
      if (fpu_ivalid) iv++;
    end
    if (t < 0) begin
      checks++;
      errors++;
      $display("FAIL rsp_wait: no rsp_valid within 200 cycles");
    end
  endtask

  task automatic reset_pulse();
    tick();
    req_valid = '0;
    never_fin = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Transaction-level reference: rotating pointer, one op in flight, response due a fixed latency after grant.
  int mptr = 0, gcyc = 0, edly = 0, eid = 0;
  bit idle_m = 1'b1, mon_en = 1'b0, eerr = 1'b0;
  bit [NREQ-1:0] ack = '0;
  logic [5:0] eop = '0;
  logic [W-1:0] ea = '0, eb = '0, edata = '0;
  logic [TAGW-1:0] etag = '0;

  always @(negedge clk) if (mon_en) begin : mon
    int w, j, el;
    bit eiv, erv;
    el = cyc - gcyc;
    eiv = !idle_m && el >= 1 && el <= edly - 1;
    erv = !idle_m && el >= edly;
    chk("m_busy", busy, !idle_m);
    chk("m_ivalid", fpu_ivalid, eiv);
    chk("m_stall", fpu_stall, eiv);
    chk("m_fpu_op", fpu_opcode, eiv ? eop : 6'd0);
    chk("m_fpu_a", fpu_a, eiv ? ea : '0);
    chk("m_fpu_b", fpu_b, eiv ? eb : '0);
    chk("m_rsp_valid", rsp_valid, erv);
    if (erv && rsp_valid) begin
      chk("m_rsp_id", rsp_id, eid);
      chk("m_rsp_tag", rsp_tag, etag);
      chk("m_rsp_data", rsp_data, edata);
      chk("m_rsp_err", rsp_err, eerr);
    end
    w = -1;
    if (idle_m && req_valid != 0)
      for (int k = 0; k < NREQ; k++) begin
        j = (mptr + k) % NREQ;
        if (w < 0 && req_valid[j]) w = j;
      end
    chk("m_ready", req_ready, (w < 0) ? 0 : (1 << w));
    if (w >= 0) begin
      ack[w] = 1'b1;
      eid = w;
      eop = req_opcode[w*6 +: 6];
      ea = req_a[w*W +: W];
      eb = req_b[w*W +: W];
      etag = req_tag[w*TAGW +: TAGW];
      eerr = !(eop == OP_FMUL || eop == OP_FDIV);
      edly = eerr ? 1 : (eop == OP_FMUL) ? LAT_FMUL + 2 : LAT_FDIV + 2;
      edata = eerr ? '0 : ref_res(eop, ea, eb);
      gcyc = cyc;
      mptr = (w + 1) % NREQ;
      idle_m = 1'b0;
    end else if (erv && rsp_valid && rsp_ready) idle_m = 1'b1;
  end

  typedef struct {
    int id;
    logic [5:0] op;
    logic [TAGW-1:0] tag;
    int dly;
    logic err;
    bit nofin;
  } vec_t;

  task automatic run_vec(input vec_t v);
    logic [W-1:0] a, b;
    logic [NREQ-1:0] g;
    int t0, t1, iv;
    a = rnd();
    b = rnd();
    tick();
    never_fin = v.nofin;
    rsp_ready = 1'b1;
    set_req(v.id, v.op, a, b, v.tag);
    wait_grant(g, t0);
    chk("tv_grant", g, 1 << v.id);
    tick();
    req_valid = '0;
    wait_rsp(t1, iv);
    chk("tv_delay", t1 - t0, v.dly);
    chk("tv_ivalid_cycles", iv, v.dly - 1);
    chk("tv_ivalid_in_resp", fpu_ivalid, 0);
    chk("tv_id", rsp_id, v.id);
    chk("tv_tag", rsp_tag, v.tag);
    chk("tv_err", rsp_err, v.err);
    chk("tv_data", rsp_data, v.err ? '0 : ref_res(v.op, a, b));
    tick();
    never_fin = 1'b0;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    vec_t tv[6];
    logic [W-1:0] fa[NREQ], fb[NREQ], sd;
    logic [NREQ-1:0] g;
    logic [TAGW-1:0] st;
    int t0, t1, t2, tp, iv, r, guard, remain;
    bit seen;
    logic [5:0] op;
    tv[0] = '{2, OP_FMUL, 4'd5, 16, 1'b0, 1'b0};
    tv[1] = '{1, 6'h10, 4'd9, 1, 1'b1, 1'b0};
    tv[2] = '{0, OP_FDIV, 4'd3, 22, 1'b0, 1'b0};
    tv[3] = '{3, OP_FMUL, 4'hf, 16, 1'b0, 1'b0};
    tv[4] = '{3, 6'h00, 4'd0, 1, 1'b1, 1'b0};
    tv[5] = '{0, OP_FMUL, 4'd7, 65, 1'b1, 1'b1};

    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_tag", rsp_tag, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_ivalid", fpu_ivalid, 0);
    chk("rst_stall", fpu_stall, 0);
    chk("rst_fpu_op", fpu_opcode, 0);
    chk("rst_req_ready", req_ready, 0);
    tick();
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) run_vec(tv[i]);

    // All four requesters issue FDIV together from a fresh pointer.
    reset_pulse();
    tick();
    rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      fa[i] = rnd();
      fb[i] = rnd();
      set_req(i, OP_FDIV, fa[i], fb[i], TAGW'(i + 8));
    end
    tp = 0;
    for (int k = 0; k < NREQ; k++) begin
      wait_grant(g, t0);
      chk("rr_grant", g, 1 << k);
      if (k > 0) chk("rr_gap", t0 - tp, 1);
      tick();
      req_valid[k] = 1'b0;
      wait_rsp(t1, iv);
      chk("rr_delay", t1 - t0, LAT_FDIV + 2);
      chk("rr_tag", rsp_tag, k + 8);
      chk("rr_data", rsp_data, ref_res(OP_FDIV, fa[k], fb[k]));
      tp = t1;
    end
    tick();

    // Response back-pressure with other requesters waiting.
    set_req(2, OP_FMUL, fa[2], fb[2], 4'd6);
    rsp_ready = 1'b0;
    wait_grant(g, t0);
    chk("hold_grant", g, 4'b0100);
    tick();
    req_valid = '0;
    set_req(0, OP_FDIV, fa[0], fb[0], 4'd1);
    set_req(1, OP_FMUL, fa[1], fb[1], 4'd2);
    wait_rsp(t1, iv);
    chk("hold_delay", t1 - t0, LAT_FMUL + 2);
    chk("hold_data", rsp_data, ref_res(OP_FMUL, fa[2], fb[2]));
    sd = rsp_data;
    st = rsp_tag;
    repeat (10) begin
      @(negedge clk);
      chk("hold_valid", rsp_valid, 1);
      chk("hold_stable_data", rsp_data, sd);
      chk("hold_stable_tag", rsp_tag, st);
      chk("hold_stable_id", rsp_id, 2);
      chk("hold_no_ready", req_ready, 0);
      chk("hold_no_ivalid", fpu_ivalid, 0);
    end
    tick();
    rsp_ready = 1'b1;
    wait_grant(g, t2);
    chk("hold_fair_grant", g, 4'b0001);
    chk("hold_next_gap", t2 - t1, 12);
    tick();
    req_valid = '0;
    wait_rsp(t1, iv);
    chk("hold_next_delay", t1 - t2, LAT_FDIV + 2);
    tick();

    // Reset in the seventh BUSY cycle abandons the operation and the pointer.
    set_req(1, OP_FMUL, fa[1], fb[1], 4'd4);
    wait_grant(g, t0);
    chk("rbusy_grant", g, 4'b0010);
    tick();
    req_valid = '0;
    repeat (6) tick();
    chk("rbusy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("rbusy_busy", busy, 0);
    chk("rbusy_ivalid", fpu_ivalid, 0);
    chk("rbusy_stall", fpu_stall, 0);
    chk("rbusy_fpu_op", fpu_opcode, 0);
    chk("rbusy_fpu_a", fpu_a, 0);
    chk("rbusy_fpu_b", fpu_b, 0);
    chk("rbusy_rsp_valid", rsp_valid, 0);
    chk("rbusy_rsp_tag", rsp_tag, 0);
    chk("rbusy_rsp_id", rsp_id, 0);
    tick();
    tick();
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    chk("rbusy_no_rsp", seen, 0);
    tick();
    set_req(3, OP_FMUL, fa[3], fb[3], 4'd3);
    set_req(0, OP_FMUL, fa[0], fb[0], 4'd2);
    wait_grant(g, t0);
    chk("rbusy_ptr0_grant", g, 4'b0001);
    tick();
    req_valid = '0;
    wait_rsp(t1, iv);
    chk("rbusy_after_delay", t1 - t0, LAT_FMUL + 2);
    chk("rbusy_after_tag", rsp_tag, 2);
    chk("rbusy_after_data", rsp_data, ref_res(OP_FMUL, fa[0], fb[0]));
    tick();

    // Randomized traffic checked cycle by cycle against the monitor model.
    reset_pulse();
    mptr = 0;
    idle_m = 1'b1;
    ack = '0;
    mon_en = 1'b1;
    remain = 60;
    guard = 0;
    while ((remain > 0 || req_valid != 0 || !idle_m) && guard < 20000) begin
      tick();
      guard++;
      for (int i = 0; i < NREQ; i++) begin
        if (ack[i]) begin
          req_valid[i] = 1'b0;
          ack[i] = 1'b0;
        end else if (!req_valid[i] && remain > 0 && $urandom_range(0, 3) == 0) begin
          r = $urandom_range(0, 4);
          op = (r < 2) ? OP_FMUL : (r < 4) ? OP_FDIV : 6'($urandom_range(0, 63));
          if (r == 4 && (op == OP_FMUL || op == OP_FDIV)) op = 6'h3f;
          set_req(i, op, rnd(), rnd(), TAGW'($urandom));
          remain--;
        end
      end
      rsp_ready = $urandom_range(0, 3) != 0;
    end
    mon_en = 1'b0;
    if (guard >= 20000) begin
      checks++;
      errors++;
      $display("FAIL random_drain: traffic did not drain within 20000 cycles");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fpu_md_scheduler.md
Name: fpu_md_scheduler

Overview:
- Shares one FpuMultDiv-style multiply/divide unit between NREQ requesters, such as lanes or issue slots.
- Round-robin arbitration picks one request at a time.
- Holds the unit's ivalid, opcode and operands stable for the whole operation and captures the result on finish.
- Returns the result with requester id and tag over a valid/ready response port.
- Sits between the issue stage and the shared FP mult/div datapath.

Parameters:
- NREQ, 4, number of requesters (≥2)
- N, 32, bits per lane element
- L, 4, lanes; operand/result width is N*L
- TAGW, 4, per-request tag width
- FMUL, 6'h37, multiply opcode
- FDIV, 6'h38, divide opcode
- TIMEOUT, 64, maximum BUSY cycles before the watchdog fires

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept (one-hot or zero)
- req_opcode  in  6*NREQ  opcode, requester i at [6i+5:6i]
- req_a  in  N*L*NREQ  operand A per requester
- req_b  in  N*L*NREQ  operand B per requester
- req_tag  in  TAGW*NREQ  opaque tag per requester
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accept
- rsp_id  out  $clog2(NREQ)  granted requester index
- rsp_tag  out  TAGW  echoed tag
- rsp_data  out  N*L  result
- rsp_err  out  1  illegal opcode or timeout
- fpu_ivalid  out  1  drives the unit's ivalid
- fpu_opcode  out  6  drives the unit's opcode
- fpu_a, fpu_b  out  N*L  drive the unit's operands
- fpu_stall  out  1  drives the unit's stall
- fpu_o  in  N*L  unit result
- fpu_finish  in  1  unit finish
- busy  out  1  state != IDLE

Behaviour:
- States: IDLE, BUSY, RESP.
- Reset (async, rst_n=0):
  - state=IDLE, rr_ptr=0, all outputs 0, rsp_data=0.
  - Reset mid-operation abandons the operation. fpu_ivalid=0 clears the unit's count on the next clk edge. No response is issued.
- IDLE:
  - Round-robin search starts at rr_ptr. The winner w is the first i with req_valid[i]=1.
  - req_ready[w]=1 combinationally in the same cycle; all other bits are 0.
  - At the clock edge, capture opcode, A, B, tag and id=w, and set rr_ptr=(w+1) mod NREQ.
  - If the opcode is FMUL or FDIV, go to BUSY. Otherwise go to RESP with rsp_err=1 and rsp_data=0; the unit is never driven.
  - No valid request: stay in IDLE and hold rr_ptr.
- BUSY:
  - fpu_ivalid=1 and fpu_stall=1. fpu_opcode, fpu_a and fpu_b come from the captured registers and are stable every cycle.
  - Cycle counter cnt starts at 0 on entry and increments each cycle.
  - fpu_finish=1: capture fpu_o into rsp_data, set rsp_err=0, go to RESP.
  - Otherwise, if cnt==TIMEOUT-1: rsp_data=0, rsp_err=1, go to RESP.
  - If finish and timeout occur in the same cycle, finish wins.
- RESP:
  - fpu_ivalid=0, so the unit count returns to 0. fpu_stall=0.
  - rsp_valid=1. rsp_id, rsp_tag, rsp_data and rsp_err are held stable until rsp_ready=1.
  - On the handshake, go to IDLE. No new grant happens in that cycle, which guarantees at least one ivalid=0 cycle between operations.
- fpu_opcode, fpu_a and fpu_b are 0 outside BUSY.
- Timing, with the grant in cycle 0:
  - BUSY occupies cycles 1..latency+1 and finish is visible in cycle latency+1.
  - rsp_valid rises in cycle latency+2: 16 for FMUL (latency 14), 22 for FDIV (latency 20).
  - Illegal opcode: rsp_valid in cycle 1.
- req_ready is never asserted outside IDLE, and never when the corresponding req_valid=0.
- Fairness: the requester granted last has the lowest priority in the next arbitration.

Decomposition:
- Shared package:
  - FMUL and FDIV opcode constants.
  - State encoding (IDLE=2'd0, BUSY=2'd1, RESP=2'd2).
  - Latency constants 14 and 20 for benches.
- One sub-module: rr_arbiter (NREQ-wide request vector, pointer in; one-hot grant and index out). It is combinational and reusable for other shared FP units.

Test Plan:
- Single FMUL from requester 2 with tag 5; unit model finish at count 14; rsp_ready=1 → rsp_valid cycle 16, rsp_id=2, rsp_tag=5, rsp_data=model product, rsp_err=0.
- Requesters 0..3 all valid with FDIV, rsp_ready always 1 → grants in order 0,1,2,3. Each response arrives 22 cycles after its grant. Each next grant comes exactly 1 cycle after the previous response handshake.
- Illegal opcode 6'h10 from requester 1 → rsp_valid cycle 1, rsp_err=1, rsp_data=0; fpu_ivalid never asserted.
- Unit model never asserts finish → rsp_err=1 after exactly 64 BUSY cycles; fpu_ivalid drops in the RESP cycle.
- FMUL done, rsp_ready held 0 for 10 cycles → rsp fields stable all 10 cycles, no req_ready asserted, fpu_ivalid=0 throughout.
- rst_n pulsed low in BUSY cycle 7 → outputs 0 immediately, state IDLE, no response. A new request after reset completes normally with rr_ptr=0.
